// File: rtl/stack_seq.sv
// Stack/ALU command sequencer for the dual-stack A/B datapath.
// Issues push/pop strobes and selects in phase order and tracks stack occupancy.
//
// state | meaning
// IDLE  | ready for a command; legality is judged here against current counts
// PH1   | first (or only) strobe phase of the latched op
// PH2   | ADD/SUB result pushed back onto A
module stack_seq #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int PW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  input  logic          great,
  output logic          pushA,
  output logic          pushB,
  output logic          popA,
  output logic          popB,
  output logic [1:0]    alu_sel,
  output logic [1:0]    d_sel,
  output logic [DW-1:0] wr_data,
  output logic [PW-1:0] cntA,
  output logic [PW-1:0] cntB,
  output logic          fullA,
  output logic          fullB,
  output logic          emptyA,
  output logic          emptyB,
  output logic          gt_flag,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, PH1, PH2} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSHA = 3'd1;
  localparam logic [2:0] OP_PUSHB = 3'd2;
  localparam logic [2:0] OP_POPA  = 3'd3;
  localparam logic [2:0] OP_POPB  = 3'd4;
  localparam logic [2:0] OP_MOVAB = 3'd5;
  localparam logic [2:0] OP_ADD   = 3'd6;
  localparam logic [2:0] OP_SUB   = 3'd7;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_CMP  = 2'd2;
  localparam logic [1:0] ALU_IDLE = 2'd3;

  localparam logic [1:0] D_WR    = 2'd0;
  localparam logic [1:0] D_ALU   = 2'd1;
  localparam logic [1:0] D_OTHER = 2'd2;

  localparam logic [PW-1:0] CNT_MAX = PW'(DEPTH);

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic       cmp_q;
  logic       accept;
  logic       legal;

  function automatic logic [PW-1:0] cnt_step(input logic [PW-1:0] c,
                                             input logic inc, input logic dec);
    if (inc && !dec && c != CNT_MAX) return c + PW'(1);
    if (dec && !inc && c != '0)      return c - PW'(1);
    return c;
  endfunction

  assign fullA     = (cntA == CNT_MAX);
  assign fullB     = (cntB == CNT_MAX);
  assign emptyA    = (cntA == '0);
  assign emptyB    = (cntB == '0);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    legal = 1'b1;
    case (cmd_op)
      OP_PUSHA:       legal = !fullA;
      OP_PUSHB:       legal = !fullB;
      OP_POPA:        legal = !emptyA;
      OP_POPB:        legal = !emptyB;
      OP_MOVAB:       legal = !emptyA && !fullB;
      OP_ADD, OP_SUB: legal = !emptyA && !emptyB;
      default:        legal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Rejected commands are still consumed, so op/data latch on every accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_NOP;
      cmp_q   <= 1'b0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept) begin
        op_q    <= cmd_op;
        cmp_q   <= cmd_data[0];
        wr_data <= cmd_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pushA     = 1'b0;
    pushB     = 1'b0;
    popA      = 1'b0;
    popB      = 1'b0;
    alu_sel   = ALU_IDLE;
    d_sel     = D_WR;
    case (state)
      IDLE: begin
        if (accept && legal) state_nxt = PH1;
      end
      PH1: begin
        state_nxt = IDLE;
        case (op_q)
          OP_PUSHA: pushA = 1'b1;
          OP_PUSHB: pushB = 1'b1;
          OP_POPA:  popA  = 1'b1;
          OP_POPB:  popB  = 1'b1;
          OP_MOVAB: begin
            popA  = 1'b1;
            pushB = 1'b1;
            d_sel = D_OTHER;
          end
          OP_ADD, OP_SUB: begin
            popA      = 1'b1;
            popB      = 1'b1;
            alu_sel   = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
            state_nxt = PH2;
          end
          default: begin
            if (cmp_q) alu_sel = ALU_CMP;
          end
        endcase
      end
      PH2: begin
        // ALU select held so the result stays valid while it is pushed.
        pushA     = 1'b1;
        d_sel     = D_ALU;
        alu_sel   = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntA    <= '0;
      cntB    <= '0;
      gt_flag <= 1'b0;
    end else begin
      cntA <= cnt_step(cntA, pushA, popA);
      cntB <= cnt_step(cntB, pushB, popB);
      if (state == PH1 && op_q == OP_NOP && cmp_q) gt_flag <= great;
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Randomized bench for stack_seq: a transaction-level model schedules the expected
// per-cycle strobe pattern of each accepted command and tracks stack sizes.
module tb_stack_seq;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int PW    = 6;

  localparam logic [2:0] NOP = 3'd0, PUSHA = 3'd1, PUSHB = 3'd2, POPA = 3'd3,
                         POPB = 3'd4, MOVAB = 3'd5, ADD = 3'd6, SUB = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          great = 1'b0;
  logic          pushA, pushB, popA, popB;
  logic [1:0]    alu_sel, d_sel;
  logic [DW-1:0] wr_data;
  logic [PW-1:0] cntA, cntB;
  logic          fullA, fullB, emptyA, emptyB, gt_flag, err;

  stack_seq #(.DW(DW), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .great(great),
    .pushA(pushA), .pushB(pushB), .popA(popA), .popB(popB),
    .alu_sel(alu_sel), .d_sel(d_sel), .wr_data(wr_data),
    .cntA(cntA), .cntB(cntB), .fullA(fullA), .fullB(fullB),
    .emptyA(emptyA), .emptyB(emptyB), .gt_flag(gt_flag), .err(err)
  );

  always #5 clk = ~clk;

  // One cycle's worth of expected datapath control; alu < 0 means not checked.
  typedef struct {
    bit pa, pb, opa, opb;
    int alu;
    int dsel;
    bit cap;
  } phase_t;

  phase_t exp_q[$];
  int     ca, cb;
  logic [DW-1:0] wr_m;
  bit     gt_m, err_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic phase_t mk(bit pa, bit pb, bit opa, bit opb, int alu, int dsel, bit cap);
    phase_t p;
    p.pa = pa; p.pb = pb; p.opa = opa; p.opb = opb;
    p.alu = alu; p.dsel = dsel; p.cap = cap;
    return p;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    ca = 0; cb = 0; wr_m = '0; gt_m = 1'b0; err_m = 1'b0;
  endtask

  task automatic compare_outputs();
    phase_t e;
    e = (exp_q.size() > 0) ? exp_q[0] : mk(0, 0, 0, 0, 3, 0, 0);
    check_eq("ready",   cmd_ready, exp_q.size() == 0);
    check_eq("pushA",   pushA, e.pa);
    check_eq("pushB",   pushB, e.pb);
    check_eq("popA",    popA,  e.opa);
    check_eq("popB",    popB,  e.opb);
    if (e.alu >= 0) check_eq("alu_sel", alu_sel, e.alu);
    check_eq("d_sel",   d_sel, e.dsel);
    check_eq("wr_data", wr_data, wr_m);
    check_eq("cntA",    cntA, ca);
    check_eq("cntB",    cntB, cb);
    check_eq("fullA",   fullA,  ca == DEPTH);
    check_eq("fullB",   fullB,  cb == DEPTH);
    check_eq("emptyA",  emptyA, ca == 0);
    check_eq("emptyB",  emptyB, cb == 0);
    check_eq("gt_flag", gt_flag, gt_m);
    check_eq("err",     err, err_m);
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_step();
    phase_t e;
    bit legal;
    err_m = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ca = ca + int'(e.pa) - int'(e.opa);
      cb = cb + int'(e.pb) - int'(e.opb);
      if (e.cap) gt_m = great;
    end else if (cmd_valid) begin
      wr_m = cmd_data;
      case (cmd_op)
        PUSHA:    legal = ca < DEPTH;
        PUSHB:    legal = cb < DEPTH;
        POPA:     legal = ca > 0;
        POPB:     legal = cb > 0;
        MOVAB:    legal = ca > 0 && cb < DEPTH;
        ADD, SUB: legal = ca > 0 && cb > 0;
        default:  legal = 1'b1;
      endcase
      if (!legal) err_m = 1'b1;
      else begin
        case (cmd_op)
          PUSHA: exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 0));
          PUSHB: exp_q.push_back(mk(0, 1, 0, 0, 3, 0, 0));
          POPA:  exp_q.push_back(mk(0, 0, 1, 0, 3, 0, 0));
          POPB:  exp_q.push_back(mk(0, 0, 0, 1, 3, 0, 0));
          MOVAB: exp_q.push_back(mk(0, 1, 1, 0, 3, 2, 0));
          ADD, SUB: begin
            exp_q.push_back(mk(0, 0, 1, 1, (cmd_op == SUB) ? 1 : 0, 0, 0));
            exp_q.push_back(mk(1, 0, 0, 0, -1, 1, 0));
          end
          default: exp_q.push_back(cmd_data[0] ? mk(0, 0, 0, 0, 2, 0, 1)
                                               : mk(0, 0, 0, 0, 3, 0, 0));
        endcase
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [2:0] op, input logic [DW-1:0] d, input bit g);
    @(negedge clk);
    compare_outputs();
    cmd_valid = v; cmd_op = op; cmd_data = d; great = g;
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit v;
    logic [2:0] op;
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Single PUSHA: strobe one cycle after accept, count after the strobe
    cycle(1, PUSHA, 16'h1234, 0);
    #1;
    check_eq("t1_pushA", pushA, 1);
    check_eq("t1_wr_data", wr_data, 16'h1234);
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("t1_pushA_drop", pushA, 0);
    check_eq("t1_cntA", cntA, 1);

    // Fill A, then one more push must be rejected
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1, PUSHA, 16'(i), 0);
      cycle(0, NOP, 0, 0);
    end
    #1;
    check_eq("t2_fullA", fullA, 1);
    check_eq("t2_cntA", cntA, DEPTH);
    cycle(1, PUSHA, 16'hbeef, 0);
    #1;
    check_eq("t2_err", err, 1);
    check_eq("t2_no_push", pushA, 0);
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("t2_cntA_hold", cntA, DEPTH);
    check_eq("t2_err_pulse", err, 0);

    // POPB on empty stacks
    do_reset();
    cycle(1, POPB, 0, 0);
    #1;
    check_eq("t3_err", err, 1);
    check_eq("t3_no_popB", popB, 0);
    check_eq("t3_ready", cmd_ready, 1);
    check_eq("t3_cntB", cntB, 0);

    // ADD with cntA=2, cntB=1
    cycle(1, PUSHA, 16'h0011, 0); cycle(0, NOP, 0, 0);
    cycle(1, PUSHA, 16'h0022, 0); cycle(0, NOP, 0, 0);
    cycle(1, PUSHB, 16'h0033, 0); cycle(0, NOP, 0, 0);
    cycle(1, ADD, 0, 0);
    #1;
    check_eq("t4_ph1_pops", {popA, popB, pushA}, 3'b110);
    check_eq("t4_ph1_alu", alu_sel, 0);
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("t4_ph2_pushA", {popA, popB, pushA}, 3'b001);
    check_eq("t4_ph2_dsel", d_sel, 1);
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("t4_cntA", cntA, 2);
    check_eq("t4_cntB", cntB, 0);

    // MOVAB with cntA=1
    cycle(1, POPA, 0, 0); cycle(0, NOP, 0, 0);
    cycle(1, MOVAB, 0, 0);
    #1;
    check_eq("t5_strobes", {popA, pushB, pushA, popB}, 4'b1100);
    check_eq("t5_dsel", d_sel, 2);
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("t5_cntA", cntA, 0);
    check_eq("t5_cntB", cntB, 1);

    // CMP captures great at the end of PH1
    cycle(1, NOP, 16'h0001, 0);
    cycle(0, NOP, 0, 1);
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("cmp_gt", gt_flag, 1);

    // Reset asserted during PH1 of SUB
    cycle(1, PUSHA, 16'h0044, 0); cycle(0, NOP, 0, 0);
    cycle(1, SUB, 0, 0);
    @(negedge clk);
    compare_outputs();
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_eq("t6_strobes", {pushA, pushB, popA, popB}, 4'b0000);
    check_eq("t6_cntA", cntA, 0);
    check_eq("t6_cntB", cntB, 0);
    check_eq("t6_alu", alu_sel, 3);
    check_eq("t6_gt", gt_flag, 0);
    @(negedge clk);
    rst = 1'b1;
    cycle(0, NOP, 0, 0);
    #1;
    check_eq("t6_idle_ready", cmd_ready, 1);
    check_eq("t6_no_resume", {pushA, popA, popB}, 3'b000);

    // Random traffic; alternate windows bias toward pushes to reach full stacks
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if (((i / 250) % 2) == 1 && $urandom_range(0, 3) != 0)
        op = 3'($urandom_range(1, 2));
      else
        op = 3'($urandom_range(0, 7));
      cycle(v, op, 16'($urandom), 1'($urandom));
    end
    @(negedge clk);
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
